// File: rtl/bounce_gen.sv
// Mechanical-switch bounce emulator: turns a clean level request into a chattering
// switch line with LFSR-chosen segment widths, then holds the level before accepting another request.
module bounce_gen #(
  parameter int          TICK_W  = 8,
  parameter int          BOUNCES = 3,
  parameter int          MAX_W   = 3,
  parameter int          HOLD    = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  output logic sw,
  output logic busy,
  output logic cur
);

  // state  | meaning
  // IDLE   | sw follows cur, waiting for lvl to differ from cur
  // BOUNCE | chattering: toggling sw after each LFSR-sized segment
  // SETTLE | sw held at target for HOLD ticks before cur updates
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  localparam int SEG_W  = MAX_W + 1;
  localparam int REM_W  = $clog2(2 * BOUNCES + 2);
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [REM_W-1:0]  REM_INIT  = REM_W'(2 * BOUNCES);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD);

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   presc;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_adv;
  logic [SEG_W-1:0]    seg, seg_nxt;
  logic [REM_W-1:0]    rem, rem_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic                sw_nxt, cur_nxt, target, target_nxt;
  logic                tick;

  function automatic logic [SEG_W-1:0] seg_len(input logic [15:0] v);
    return {1'b0, v[MAX_W-1:0]} + SEG_W'(1);
  endfunction

  assign tick     = (presc == '0);
  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0
  assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    sw_nxt     = sw;
    cur_nxt    = cur;
    target_nxt = target;
    lfsr_nxt   = lfsr;
    seg_nxt    = seg;
    rem_nxt    = rem;
    hold_nxt   = hold;
    case (state)
      IDLE: begin
        sw_nxt = cur;
        if (lvl != cur) begin
          sw_nxt     = lvl;
          target_nxt = lvl;
          rem_nxt    = REM_INIT;
          seg_nxt    = seg_len(lfsr);
          if (BOUNCES > 0) begin
            state_nxt = BOUNCE;
          end else begin
            state_nxt = SETTLE;
            hold_nxt  = HOLD_INIT;
          end
        end
      end
      BOUNCE: begin
        if (tick) begin
          if (seg == SEG_W'(1)) begin
            sw_nxt   = ~sw;
            lfsr_nxt = lfsr_adv;
            seg_nxt  = seg_len(lfsr_adv);
            rem_nxt  = rem - REM_W'(1);
            if (rem == REM_W'(1)) begin
              state_nxt = SETTLE;
              hold_nxt  = HOLD_INIT;
            end
          end else begin
            seg_nxt = seg - SEG_W'(1);
          end
        end
      end
      SETTLE: begin
        sw_nxt = target;
        if (tick) begin
          if (hold == HOLD_W'(1)) begin
            cur_nxt   = target;
            state_nxt = IDLE;
          end else begin
            hold_nxt = hold - HOLD_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      presc  <= '0;
      lfsr   <= SEED;
      seg    <= '0;
      rem    <= '0;
      hold   <= '0;
      sw     <= 1'b0;
      cur    <= 1'b0;
      target <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc + TICK_W'(1);
      lfsr   <= lfsr_nxt;
      seg    <= seg_nxt;
      rem    <= rem_nxt;
      hold   <= hold_nxt;
      sw     <= sw_nxt;
      cur    <= cur_nxt;
      target <= target_nxt;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: a clean-edge instance checked against a hand-computed vector table,
// and a bouncing instance checked segment by segment against a reference LFSR model.
module tb_bounce_gen;

  localparam int B_A    = 2;
  localparam int HOLD_A = 3;

  logic clk = 1'b0;
  logic reset;
  logic lvl_a, lvl_b;
  logic sw_a, busy_a, cur_a;
  logic sw_b, busy_b, cur_b;

  int errors = 0;
  int checks = 0;

  logic [1:0] tpre;
  logic       tick_e;
  int         en;
  int         rec [3][5];

  typedef struct {
    logic lvl;
    int   n;
    logic sw;
    logic busy;
    logic cur;
  } vec_t;
  vec_t vecs [11];

  bounce_gen #(.TICK_W(2), .BOUNCES(B_A), .MAX_W(3), .HOLD(HOLD_A), .SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(reset), .lvl(lvl_a), .sw(sw_a), .busy(busy_a), .cur(cur_a));

  bounce_gen #(.TICK_W(2), .BOUNCES(0), .MAX_W(3), .HOLD(4), .SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(reset), .lvl(lvl_b), .sw(sw_b), .busy(busy_b), .cur(cur_b));

  always #5 clk = ~clk;

  // Prescaler model: tick_e tells whether the edge just taken was a tick edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tpre   <= 2'd0;
      tick_e <= 1'b0;
      en     <= 0;
    end else begin
      tick_e <= (tpre == 2'd0);
      tpre   <= tpre + 2'd1;
      en     <= en + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_seq(input logic tgt, input logic [15:0] l0, input bit glitch,
                         input int slot, output logic [15:0] l_end);
    logic [15:0] l;
    int ticks, toggles, to_tgt, away, gphase;
    logic prev;
    bit done, cur_bad;
    l = l0; ticks = 0; toggles = 0; to_tgt = 0; away = 0; gphase = 0;
    done = 0; cur_bad = 0;
    @(posedge clk); #1;
    chk("first_edge_sw", int'(sw_a), int'(tgt));
    chk("first_edge_busy", int'(busy_a), 1);
    if (sw_a == tgt) to_tgt++;
    prev = sw_a;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk); #1;
      if (tick_e) ticks++;
      if (glitch && gphase == 1) begin
        lvl_a  = tgt;
        gphase = 2;
      end
      if (sw_a !== prev) begin
        toggles++;
        chk("seg_len", ticks, int'(l[2:0]) + 1);
        l = lfsr_step(l);
        ticks = 0;
        if (sw_a == tgt) to_tgt++; else away++;
        if (toggles <= 4) rec[slot][toggles-1] = en;
        prev = sw_a;
        if (glitch && toggles == 2 && gphase == 0) begin
          lvl_a  = ~tgt;
          gphase = 1;
        end
      end
      if (busy_a && cur_a !== ~tgt) cur_bad = 1;
      if (!busy_a) begin
        done = 1;
        rec[slot][4] = en;
      end
    end
    chk("seq_done", int'(done), 1);
    chk("hold_len", ticks, HOLD_A);
    chk("toggles", toggles, 2 * B_A);
    chk("edges_to_target", to_tgt, B_A + 1);
    chk("edges_away", away, B_A);
    chk("cur_end", int'(cur_a), int'(tgt));
    chk("sw_end", int'(sw_a), int'(tgt));
    chk("cur_stable_busy", int'(cur_bad), 0);
    l_end = l;
  endtask

  initial begin
    logic [15:0] lf;
    bit idle_bad;

    // clean-edge instance (BOUNCES=0, HOLD=4); ticks fall on edges 0,4,8,...
    vecs[0]  = '{1'b0, 1,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1,  1'b1, 1'b1, 1'b0};  // edge 1: clean rise
    vecs[2]  = '{1'b1, 14, 1'b1, 1'b1, 1'b0};  // edge 15: still holding
    vecs[3]  = '{1'b1, 1,  1'b1, 1'b0, 1'b1};  // edge 16: 4th tick, settled
    vecs[4]  = '{1'b0, 1,  1'b0, 1'b1, 1'b1};  // edge 17: clean fall
    vecs[5]  = '{1'b0, 14, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1,  1'b0, 1'b0, 1'b0};  // edge 32
    vecs[7]  = '{1'b0, 3,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1,  1'b1, 1'b1, 1'b0};  // edge 36 is a tick: not counted
    vecs[9]  = '{1'b1, 15, 1'b1, 1'b1, 1'b0};  // edge 51
    vecs[10] = '{1'b1, 1,  1'b1, 1'b0, 1'b1};  // edge 52

    reset = 1'b0; lvl_a = 1'b0; lvl_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw_a", int'(sw_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_cur_a", int'(cur_a), 0);
    chk("rst_sw_b", int'(sw_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_cur_b", int'(cur_b), 0);

    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      lvl_b = vecs[i].lvl;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_sw", i), int'(sw_b), int'(vecs[i].sw));
      chk($sformatf("vec%0d_busy", i), int'(busy_b), int'(vecs[i].busy));
      chk($sformatf("vec%0d_cur", i), int'(cur_b), int'(vecs[i].cur));
    end

    // bouncing rise started on a tick edge, with a lvl pulse inside the busy window
    reset = 1'b0; lvl_b = 1'b0; lvl_a = 1'b1;
    @(negedge clk) reset = 1'b1;
    run_seq(1'b1, 16'hACE1, 1'b1, 0, lf);
    idle_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy_a || sw_a !== 1'b1) idle_bad = 1;
    end
    chk("glitch_no_new_seq", int'(idle_bad), 0);
    chk("glitch_cur", int'(cur_a), 1);

    // bouncing fall continues the LFSR sequence
    lvl_a = 1'b0;
    run_seq(1'b0, lf, 1'b0, 2, lf);

    // async reset in the middle of BOUNCE with sw high
    lvl_a = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_sw", int'(sw_a), 1);
    chk("pre_reset_busy", int'(busy_a), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_sw", int'(sw_a), 0);
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_cur", int'(cur_a), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_seq(1'b1, 16'hACE1, 1'b0, 1, lf);
    for (int i = 0; i < 5; i++)
      chk($sformatf("determinism_%0d", i), rec[1][i], rec[0][i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
